// File: rtl/fifo_pll_pkg.sv
// fifo_pll_pkg: shared types and defaults for the FIFO PLL lock sequencer.
// Provides the FSM state enum, 133 MHz timing defaults and timer sizing.
package fifo_pll_pkg;

  typedef enum logic [2:0] {
    ST_ASSERT,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_READY,
    ST_FAIL
  } pll_state_e;

  // Defaults for a 133 MHz refclk.
  localparam int unsigned DEF_RST_CYCLES   = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT = 133000;
  localparam int unsigned DEF_LOCK_STABLE  = 1024;
  localparam int unsigned DEF_MAX_RETRIES  = 3;

  // Bits needed for a timer that counts 0..max(a,b,c)-1.
  function automatic int unsigned cnt_width(
    input int unsigned a,
    input int unsigned b,
    input int unsigned c
  );
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

  // 133000 needs 18 bits; two bits of headroom for slower refclks.
  localparam int unsigned DEF_CNT_W = 20;

endpackage

// File: rtl/fifo_pll_sync2.sv
// fifo_pll_sync2: generic two-flop synchronizer for async status inputs.
// Ports: clk_i clock, rst_i sync active-high reset, d_i async in, q_o sync out.
module fifo_pll_sync2 #(
  parameter int unsigned W = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/fifo_pll_lock_ctrl.sv
// fifo_pll_lock_ctrl: PLL reset pulse, lock wait/qualify, retry and fail.
// Ports: refclk clock; rst sync reset; pll_locked async lock; relock_req
//   restart; pll_rst PLL reset; clk_ready qualified; lock_lost pulse;
//   fail sticky; retry_cnt retries used.
module fifo_pll_lock_ctrl
  import fifo_pll_pkg::*;
#(
  parameter int unsigned RST_CYCLES   = DEF_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int unsigned LOCK_STABLE  = DEF_LOCK_STABLE,
  parameter int unsigned MAX_RETRIES  = DEF_MAX_RETRIES,
  parameter int unsigned CNT_W        = DEF_CNT_W
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       clk_ready,
  output logic       lock_lost,
  output logic       fail,
  output logic [1:0] retry_cnt
);

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] T_ONE    = CNT_W'(1);
  localparam logic [1:0]       R_MAX    = 2'(MAX_RETRIES);

  pll_state_e       state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [1:0]       retry_q, retry_d;

  logic pll_rst_q, pll_rst_d;
  logic clk_ready_q, clk_ready_d;
  logic lock_lost_q, lock_lost_d;
  logic fail_q, fail_d;

  logic locked_s;

  fifo_pll_sync2 #(
    .W (1)
  ) u_sync_locked (
    .clk_i (refclk),
    .rst_i (rst),
    .d_i   (pll_locked),
    .q_o   (locked_s)
  );

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q <= ST_ASSERT;
      timer_q <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      retry_q <= retry_d;
    end
  end

  // relock_req outranks every in-state event, including lock loss.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    retry_d = retry_q;
    if (relock_req) begin
      state_d = ST_ASSERT;
      timer_d = '0;
      retry_d = '0;
    end else begin
      unique case (state_q)
        ST_ASSERT: begin
          if (timer_q == RST_LAST) begin
            state_d = ST_WAIT_LOCK;
            timer_d = '0;
          end else begin
            timer_d = timer_q + T_ONE;
          end
        end
        ST_WAIT_LOCK: begin
          if (locked_s) begin
            state_d = ST_STABLE;
            timer_d = '0;
          end else if (timer_q == TMO_LAST) begin
            timer_d = '0;
            if (retry_q >= R_MAX) begin
              state_d = ST_FAIL;
            end else begin
              state_d = ST_ASSERT;
              retry_d = retry_q + 2'd1;
            end
          end else begin
            timer_d = timer_q + T_ONE;
          end
        end
        ST_STABLE: begin
          // A dropout restarts the lock timeout; retries are kept.
          if (!locked_s) begin
            state_d = ST_WAIT_LOCK;
            timer_d = '0;
          end else if (timer_q == STB_LAST) begin
            state_d = ST_READY;
            timer_d = '0;
            retry_d = '0;
          end else begin
            timer_d = timer_q + T_ONE;
          end
        end
        ST_READY: begin
          if (!locked_s) begin
            state_d = ST_ASSERT;
            timer_d = '0;
            retry_d = '0;
          end
        end
        ST_FAIL: begin
          timer_d = '0;
        end
        default: begin
          state_d = ST_ASSERT;
          timer_d = '0;
          retry_d = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they land on the same
  // edge as the transition.
  always_comb begin
    pll_rst_d   = (state_d == ST_ASSERT) || (state_d == ST_FAIL);
    clk_ready_d = (state_d == ST_READY);
    fail_d      = (state_d == ST_FAIL);
    lock_lost_d = !relock_req && (state_q == ST_READY) && !locked_s;
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      pll_rst_q   <= 1'b1;
      clk_ready_q <= 1'b0;
      lock_lost_q <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      pll_rst_q   <= pll_rst_d;
      clk_ready_q <= clk_ready_d;
      lock_lost_q <= lock_lost_d;
      fail_q      <= fail_d;
    end
  end

  assign pll_rst   = pll_rst_q;
  assign clk_ready = clk_ready_q;
  assign lock_lost = lock_lost_q;
  assign fail      = fail_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_fifo_pll_lock_ctrl.sv
// tb_fifo_pll_lock_ctrl: directed plus random stimulus for the PLL sequencer.
// Outputs are compared every cycle against a phase/elapsed-time model.
module tb_fifo_pll_lock_ctrl;

  localparam int RSTC = 4;
  localparam int TMO  = 20;
  localparam int STB  = 8;
  localparam int MAXR = 2;

  localparam int PH_RST  = 0;
  localparam int PH_WAIT = 1;
  localparam int PH_STAB = 2;
  localparam int PH_RDY  = 3;
  localparam int PH_FAIL = 4;

  logic       refclk;
  logic       rst;
  logic       pll_locked;
  logic       relock_req;
  logic       pll_rst;
  logic       clk_ready;
  logic       lock_lost;
  logic       fail;
  logic [1:0] retry_cnt;

  int checks   = 0;
  int failures = 0;
  int lost_cnt = 0;
  bit check_en = 0;

  typedef struct {
    int   phase;
    int   elapsed;
    int   retries;
    logic hist0;
    logic hist1;
    int   pll_rst;
    int   clk_ready;
    int   lock_lost;
    int   fail;
  } model_t;

  model_t m;

  fifo_pll_lock_ctrl #(
    .RST_CYCLES   (RSTC),
    .LOCK_TIMEOUT (TMO),
    .LOCK_STABLE  (STB),
    .MAX_RETRIES  (MAXR),
    .CNT_W        (5)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .relock_req (relock_req),
    .pll_rst    (pll_rst),
    .clk_ready  (clk_ready),
    .lock_lost  (lock_lost),
    .fail       (fail),
    .retry_cnt  (retry_cnt)
  );

  initial begin
    refclk = 1'b0;
    forever #5 refclk = ~refclk;
  end

  function automatic void chk(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, got, exp, $time);
    end
  endfunction

  // Phase model: the lock seen by the sequencer is the input value from
  // two edges earlier; each phase is measured in elapsed edges.
  function automatic model_t model_step(model_t c, logic r,
                                        logic lk, logic rq);
    model_t n;
    logic   seen;
    n = c;
    n.lock_lost = 0;
    if (r) begin
      n.phase   = PH_RST;
      n.elapsed = 0;
      n.retries = 0;
      n.hist0   = 1'b0;
      n.hist1   = 1'b0;
    end else begin
      seen    = c.hist1;
      n.hist1 = c.hist0;
      n.hist0 = lk;
      if (rq) begin
        n.phase   = PH_RST;
        n.elapsed = 0;
        n.retries = 0;
      end else if (c.phase == PH_RST) begin
        n.elapsed = c.elapsed + 1;
        if (n.elapsed == RSTC) begin
          n.phase   = PH_WAIT;
          n.elapsed = 0;
        end
      end else if (c.phase == PH_WAIT) begin
        if (seen) begin
          n.phase   = PH_STAB;
          n.elapsed = 0;
        end else begin
          n.elapsed = c.elapsed + 1;
          if (n.elapsed == TMO) begin
            n.elapsed = 0;
            if (c.retries == MAXR) begin
              n.phase = PH_FAIL;
            end else begin
              n.phase   = PH_RST;
              n.retries = c.retries + 1;
            end
          end
        end
      end else if (c.phase == PH_STAB) begin
        if (!seen) begin
          n.phase   = PH_WAIT;
          n.elapsed = 0;
        end else begin
          n.elapsed = c.elapsed + 1;
          if (n.elapsed == STB) begin
            n.phase   = PH_RDY;
            n.retries = 0;
          end
        end
      end else if (c.phase == PH_RDY) begin
        if (!seen) begin
          n.lock_lost = 1;
          n.phase     = PH_RST;
          n.elapsed   = 0;
          n.retries   = 0;
        end
      end
    end
    n.pll_rst   = (n.phase == PH_RST || n.phase == PH_FAIL) ? 1 : 0;
    n.clk_ready = (n.phase == PH_RDY) ? 1 : 0;
    n.fail      = (n.phase == PH_FAIL) ? 1 : 0;
    return n;
  endfunction

  always @(posedge refclk) begin
    m <= model_step(m, rst, pll_locked, relock_req);
  end

  always @(posedge lock_lost) lost_cnt++;

  always @(negedge refclk) begin
    if (check_en) begin
      chk("pll_rst", int'(pll_rst), m.pll_rst);
      chk("clk_ready", int'(clk_ready), m.clk_ready);
      chk("lock_lost", int'(lock_lost), m.lock_lost);
      chk("fail", int'(fail), m.fail);
      chk("retry_cnt", int'(retry_cnt), m.retries);
    end
  end

  task automatic pulse_width(output int w);
    w = 0;
    for (int i = 0; i < 200; i++) begin
      if (!pll_rst) break;
      w++;
      @(negedge refclk);
    end
  endtask

  task automatic low_width(output int w);
    w = 0;
    for (int i = 0; i < 200; i++) begin
      if (pll_rst) break;
      w++;
      @(negedge refclk);
    end
  endtask

  task automatic edges_until_ready(output int e);
    e = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge refclk);
      e++;
      if (clk_ready) break;
    end
  endtask

  task automatic wait_rst(input logic v, input string name);
    for (int i = 0; i < 200; i++) begin
      if (pll_rst == v) break;
      @(negedge refclk);
    end
    chk(name, int'(pll_rst), int'(v));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int e;
    int base;
    int run;
    rst        = 1'b1;
    pll_locked = 1'b0;
    relock_req = 1'b0;
    @(posedge refclk);
    check_en = 1'b1;
    repeat (3) @(negedge refclk);
    chk("reset_pll_rst", int'(pll_rst), 1);
    chk("reset_clk_ready", int'(clk_ready), 0);
    chk("reset_retry", int'(retry_cnt), 0);

    // 1: clean bring-up
    rst = 1'b0;
    pulse_width(w);
    chk("s1_rst_width", w, 4);
    repeat (5) @(negedge refclk);
    pll_locked = 1'b1;
    edges_until_ready(e);
    chk("s1_ready_edges", e - 1, 10);
    chk("s1_fail", int'(fail), 0);
    chk("s1_retry", int'(retry_cnt), 0);

    // 3: one-cycle lock dropout in READY
    base = lost_cnt;
    pll_locked = 1'b0;
    e = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge refclk);
      e++;
      if (e == 1) pll_locked = 1'b1;
      if (lock_lost) break;
    end
    chk("s3_lost_latency", e - 1, 2);
    chk("s3_ready_fall", int'(clk_ready), 0);
    pulse_width(w);
    chk("s3_rst_width", w, 4);
    edges_until_ready(e);
    chk("s3_ready_back", int'(clk_ready), 1);
    chk("s3_lost_once", lost_cnt - base, 1);

    // 4: dropout in STABLE after one retry
    base = lost_cnt;
    relock_req = 1'b1;
    pll_locked = 1'b0;
    @(negedge refclk);
    relock_req = 1'b0;
    wait_rst(1'b0, "s4_fall1");
    wait_rst(1'b1, "s4_retry_pulse");
    chk("s4_retry1", int'(retry_cnt), 1);
    wait_rst(1'b0, "s4_fall2");
    pll_locked = 1'b1;
    repeat (4) @(negedge refclk);
    pll_locked = 1'b0;
    repeat (3) @(negedge refclk);
    pll_locked = 1'b1;
    chk("s4_retry_hold", int'(retry_cnt), 1);
    chk("s4_not_ready", int'(clk_ready), 0);
    edges_until_ready(e);
    chk("s4_ready_edges", e - 1, 10);
    chk("s4_no_lost", lost_cnt - base, 0);

    // 5: relock_req meets a synchronized lock loss
    base = lost_cnt;
    pll_locked = 1'b0;
    repeat (2) @(negedge refclk);
    chk("s5_still_ready", int'(clk_ready), 1);
    relock_req = 1'b1;
    @(negedge refclk);
    relock_req = 1'b0;
    chk("s5_no_lost_pulse", int'(lock_lost), 0);
    chk("s5_ready_off", int'(clk_ready), 0);
    pulse_width(w);
    chk("s5_rst_width", w, 4);
    chk("s5_no_lost", lost_cnt - base, 0);

    // 2: no lock ever, retries then FAIL
    rst = 1'b1;
    repeat (2) @(negedge refclk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      pulse_width(w);
      chk("s2_pulse_width", w, 4);
      chk("s2_retry_step", int'(retry_cnt), k);
      low_width(w);
      chk("s2_gap", w, 20);
    end
    chk("s2_fail", int'(fail), 1);
    repeat (30) @(negedge refclk);
    chk("s2_fail_hold_rst", int'(pll_rst), 1);
    chk("s2_fail_sticky", int'(fail), 1);
    relock_req = 1'b1;
    @(negedge refclk);
    relock_req = 1'b0;
    chk("s2_fail_clear", int'(fail), 0);
    pulse_width(w);
    chk("s2_relock_width", w, 4);

    // 6: rst mid-WAIT_LOCK with one retry used
    low_width(w);
    wait_rst(1'b0, "s6_fall");
    repeat (5) @(negedge refclk);
    chk("s6_retry1", int'(retry_cnt), 1);
    rst = 1'b1;
    @(negedge refclk);
    chk("s6_pll_rst", int'(pll_rst), 1);
    chk("s6_retry0", int'(retry_cnt), 0);
    chk("s6_ready0", int'(clk_ready), 0);
    chk("s6_fail0", int'(fail), 0);
    chk("s6_lost0", int'(lock_lost), 0);
    rst = 1'b0;
    pulse_width(w);
    chk("s6_rst_width", w, 4);

    // random: lock runs, sporadic relock and reset
    run = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge refclk);
      if (run == 0) begin
        pll_locked = ($urandom_range(0, 3) != 0);
        run = pll_locked ? int'($urandom_range(1, 60))
                         : int'($urandom_range(1, 100));
      end
      run--;
      relock_req = ($urandom_range(0, 199) == 0);
      rst        = ($urandom_range(0, 999) == 0);
    end
    rst        = 1'b0;
    relock_req = 1'b0;
    repeat (5) @(negedge refclk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
